spi_flash_responder: RTL and testbench

//  Synthesizable SPI-flash target (mode 0) answering the JTAG-to-SPI bridge

---
 rtl/spi_flash_responder.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI-flash target (mode 0) emulating a serial NOR flash behind an external byte-wide array.
// Define PAGE_PROG_EN to accept page program (0x02); otherwise mem_we/mem_wdata are tied low.
module spi_flash_responder #(
   parameter int unsigned ADDR_W      = 16,
   parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_csn,
   input  logic              spi_sck,
   input  logic              spi_sdi,
   output logic              spi_sdo,
   output logic              spi_sdo_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_rdata,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   output logic [7:0]        cmd_code,
   output logic              cmd_valid
);

   localparam logic [7:0] OpPp   = 8'h02;
   localparam logic [7:0] OpRead = 8'h03;
   localparam logic [7:0] OpWrdi = 8'h04;
   localparam logic [7:0] OpRdsr = 8'h05;
   localparam logic [7:0] OpWren = 8'h06;
   localparam logic [7:0] OpId   = 8'h9F;

   localparam logic [ADDR_W-1:0] AddrOne = 1;

   typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDataOut, StDataIn, StIgnore} state_e;

   logic [SYNC_STAGES-1:0] csn_sync_q;
   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] sdi_sync_q;
   logic                   csn_prev_q;
   logic                   sck_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csn_sync_q <= '1;
         sck_sync_q <= '0;
         sdi_sync_q <= '0;
         csn_prev_q <= 1'b1;
         sck_prev_q <= 1'b0;
      end else begin
         csn_sync_q <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
         sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
         sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
         csn_prev_q <= csn_sync_q[SYNC_STAGES-1];
         sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
      end
   end

   logic csn_s;
   logic sck_s;
   logic sdi_s;
   logic csn_fall;
   logic csn_rise;
   logic sck_rise;
   logic sck_fall;

   assign csn_s    = csn_sync_q[SYNC_STAGES-1];
   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
   assign csn_fall = csn_prev_q & ~csn_s;
   assign csn_rise = ~csn_prev_q & csn_s;
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;

   state_e            state_q, state_d;
   logic [4:0]        bit_cnt_q, bit_cnt_d;
   logic [6:0]        in_sr_q, in_sr_d;
   logic [ADDR_W-2:0] addr_sr_q, addr_sr_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [7:0]        out_sr_q, out_sr_d;
   logic [2:0]        out_cnt_q, out_cnt_d;
   logic [7:0]        nxt_q, nxt_d;
   logic [1:0]        id_idx_q, id_idx_d;
   logic              first_q, first_d;
   logic              rd_wait_q, rd_wait_d;
   logic              extra_q, extra_d;
   logic              wel_q, wel_d;
   logic              sdo_q, sdo_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_rd_q, mem_rd_d;
   logic [7:0]        cmd_code_q, cmd_code_d;
   logic              cmd_valid_q, cmd_valid_d;
`ifdef PAGE_PROG_EN
   logic              mem_we_q, mem_we_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
`endif

   logic [7:0]        opcode;
   logic [ADDR_W-1:0] addr_full;
   logic [7:0]        status_byte;
   logic [7:0]        id_byte;

   assign opcode      = {in_sr_q, sdi_s};
   assign addr_full   = {addr_sr_q, sdi_s};
   assign status_byte = {6'b0, wel_q, 1'b0};

   always_comb begin
      unique case (id_idx_q)
         2'd1:    id_byte = JEDEC_ID[15:8];
         2'd2:    id_byte = JEDEC_ID[7:0];
         default: id_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         in_sr_q     <= '0;
         addr_sr_q   <= '0;
         cur_addr_q  <= '0;
         out_sr_q    <= '0;
         out_cnt_q   <= '0;
         nxt_q       <= '0;
         id_idx_q    <= '0;
         first_q     <= 1'b0;
         rd_wait_q   <= 1'b0;
         extra_q     <= 1'b0;
         wel_q       <= 1'b0;
         sdo_q       <= 1'b0;
         mem_addr_q  <= '0;
         mem_rd_q    <= 1'b0;
         cmd_code_q  <= '0;
         cmd_valid_q <= 1'b0;
`ifdef PAGE_PROG_EN
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         in_sr_q     <= in_sr_d;
         addr_sr_q   <= addr_sr_d;
         cur_addr_q  <= cur_addr_d;
         out_sr_q    <= out_sr_d;
         out_cnt_q   <= out_cnt_d;
         nxt_q       <= nxt_d;
         id_idx_q    <= id_idx_d;
         first_q     <= first_d;
         rd_wait_q   <= rd_wait_d;
         extra_q     <= extra_d;
         wel_q       <= wel_d;
         sdo_q       <= sdo_d;
         mem_addr_q  <= mem_addr_d;
         mem_rd_q    <= mem_rd_d;
         cmd_code_q  <= cmd_code_d;
         cmd_valid_q <= cmd_valid_d;
`ifdef PAGE_PROG_EN
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      in_sr_d     = in_sr_q;
      addr_sr_d   = addr_sr_q;
      cur_addr_d  = cur_addr_q;
      out_sr_d    = out_sr_q;
      out_cnt_d   = out_cnt_q;
      nxt_d       = nxt_q;
      id_idx_d    = id_idx_q;
      first_d     = first_q;
      rd_wait_d   = mem_rd_q;
      extra_d     = extra_q;
      wel_d       = wel_q;
      sdo_d       = sdo_q;
      mem_addr_d  = mem_addr_q;
      mem_rd_d    = 1'b0;
      cmd_code_d  = cmd_code_q;
      cmd_valid_d = 1'b0;
`ifdef PAGE_PROG_EN
      mem_we_d    = 1'b0;
      mem_wdata_d = mem_wdata_q;
`endif

      // Read data lands one clk after the strobe: first byte goes straight to the shifter.
      if (rd_wait_q) begin
         if (first_q) begin
            out_sr_d = mem_rdata;
            first_d  = 1'b0;
         end else begin
            nxt_d = mem_rdata;
         end
      end

      if (csn_rise) begin
         state_d = StIdle;
         sdo_d   = 1'b0;
         if (state_q == StIgnore && !extra_q) begin
            if (cmd_code_q == OpWren) begin
               wel_d = 1'b1;
            end else if (cmd_code_q == OpWrdi) begin
               wel_d = 1'b0;
            end
         end
`ifdef PAGE_PROG_EN
         if (cmd_code_q == OpPp && (state_q == StAddr || state_q == StDataIn)) begin
            wel_d = 1'b0;
         end
`endif
      end else if (csn_fall) begin
         state_d   = StCmd;
         bit_cnt_d = '0;
         extra_d   = 1'b0;
         first_d   = 1'b0;
      end else if (state_q != StIdle) begin
         if (sck_rise) begin
            case (state_q)
               StCmd: begin
                  in_sr_d   = opcode[6:0];
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d   = '0;
                     out_cnt_d   = '0;
                     cmd_code_d  = opcode;
                     cmd_valid_d = 1'b1;
                     case (opcode)
                        OpId: begin
                           state_d  = StDataOut;
                           out_sr_d = JEDEC_ID[23:16];
                           id_idx_d = 2'd1;
                        end
                        OpRdsr: begin
                           state_d  = StDataOut;
                           out_sr_d = status_byte;
                        end
                        OpRead: state_d = StAddr;
                        OpPp: begin
`ifdef PAGE_PROG_EN
                           state_d = wel_q ? StAddr : StIgnore;
`else
                           state_d = StIgnore;
`endif
                        end
                        default: state_d = StIgnore;
                     endcase
                  end
               end
               StAddr: begin
                  addr_sr_d = addr_full[ADDR_W-2:0];
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd23) begin
                     bit_cnt_d = '0;
                     if (cmd_code_q == OpRead) begin
                        state_d    = StDataOut;
                        mem_addr_d = addr_full;
                        mem_rd_d   = 1'b1;
                        cur_addr_d = addr_full + AddrOne;
                        first_d    = 1'b1;
                     end else begin
                        state_d    = StDataIn;
                        cur_addr_d = addr_full;
                     end
                  end
               end
`ifdef PAGE_PROG_EN
               StDataIn: begin
                  in_sr_d   = opcode[6:0];
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d        = '0;
                     mem_wdata_d      = opcode;
                     mem_we_d         = 1'b1;
                     mem_addr_d       = cur_addr_q;
                     // Wrap inside the 256-byte page; upper address bits stay fixed.
                     cur_addr_d[7:0]  = cur_addr_q[7:0] + 8'd1;
                  end
               end
`endif
               StIgnore: extra_d = 1'b1;
               default: ;
            endcase
         end

         if (sck_fall && state_q == StDataOut) begin
            sdo_d     = out_sr_q[7];
            out_sr_d  = {out_sr_q[6:0], 1'b0};
            out_cnt_d = out_cnt_q + 3'd1;
            // Prefetch the following byte as the MSB of the current one leaves.
            if (out_cnt_q == 3'd0 && cmd_code_q == OpRead) begin
               mem_addr_d = cur_addr_q;
               mem_rd_d   = 1'b1;
               cur_addr_d = cur_addr_q + AddrOne;
            end
            if (out_cnt_q == 3'd7) begin
               if (cmd_code_q == OpId) begin
                  out_sr_d = id_byte;
                  id_idx_d = (id_idx_q == 2'd3) ? 2'd3 : id_idx_q + 2'd1;
               end else if (cmd_code_q == OpRdsr) begin
                  out_sr_d = status_byte;
               end else begin
                  out_sr_d = nxt_q;
               end
            end
         end
      end
   end

   assign spi_sdo    = sdo_q;
   assign spi_sdo_oe = (state_q == StDataOut) && !csn_s;
   assign mem_addr   = mem_addr_q;
   assign mem_rd     = mem_rd_q;
   assign cmd_code   = cmd_code_q;
   assign cmd_valid  = cmd_valid_q;
`ifdef PAGE_PROG_EN
   assign mem_we     = mem_we_q;
   assign mem_wdata  = mem_wdata_q;
`else
   assign mem_we     = 1'b0;
   assign mem_wdata  = 8'h00;
`endif

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: table of SPI transactions plus hand-written
// sequences for abort, WREN length, page program and asynchronous reset.
module tb_spi_flash_responder;

   localparam int unsigned ADDR_W      = 16;
   localparam int unsigned SYNC_STAGES = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              spi_csn;
   logic              spi_sck;
   logic              spi_sdi;
   logic              spi_sdo;
   logic              spi_sdo_oe;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [7:0]        mem_rdata;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        cmd_code;
   logic              cmd_valid;

   spi_flash_responder #(
      .ADDR_W      (ADDR_W),
      .JEDEC_ID    (24'hEF4018),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spi_csn    (spi_csn),
      .spi_sck    (spi_sck),
      .spi_sdi    (spi_sdi),
      .spi_sdo    (spi_sdo),
      .spi_sdo_oe (spi_sdo_oe),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_rdata  (mem_rdata),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .cmd_code   (cmd_code),
      .cmd_valid  (cmd_valid)
   );

   always #5 clk = ~clk;

   // Memory model: registered read, preloaded while reset is asserted.
   logic [7:0] mem [0:65535];
   always @(posedge clk) begin
      if (!rst_n) begin
         mem[16'h0010] <= 8'hA5;
         mem[16'h0011] <= 8'h3C;
         mem[16'hFFFF] <= 8'h5A;
         mem[16'h0000] <= 8'hC3;
         mem_rdata     <= 8'h00;
      end else begin
         if (mem_rd) mem_rdata <= mem[mem_addr];
         if (mem_we) mem[mem_addr] <= mem_wdata;
      end
   end

   int cv_cnt = 0;
   int rd_cnt = 0;
   int we_cnt = 0;
   always @(negedge clk) begin
      if (cmd_valid) cv_cnt++;
      if (mem_rd) rd_cnt++;
      if (mem_we) we_cnt++;
   end

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic half();
      repeat (6) @(negedge clk);
   endtask

   task automatic xfer(input logic [7:0] tx, input int nb, output logic [7:0] rx);
      rx = '0;
      for (int i = 0; i < nb; i++) begin
         spi_sdi = tx[7-i];
         half();
         rx[7-i] = spi_sdo;
         spi_sck = 1'b1;
         half();
         spi_sck = 1'b0;
      end
   endtask

   task automatic txn(input logic [63:0] tx, input int n, output logic [63:0] rx);
      logic [7:0] b;
      rx = '0;
      spi_csn = 1'b0;
      half();
      for (int k = 0; k < n; k++) begin
         xfer(tx[63-8*k -: 8], 8, b);
         rx[63-8*k -: 8] = b;
      end
      half();
      spi_csn = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   typedef struct {
      string       name;
      int          nbytes;
      logic [63:0] tx;
      logic [63:0] rx;
      logic [7:0]  chk;
      int          rd_min;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs [NV];

   task automatic set_vec(input int i, input string name, input int n, input logic [63:0] tx,
                          input logic [63:0] rx, input logic [7:0] chk, input int rd_min);
      vecs[i].name   = name;
      vecs[i].nbytes = n;
      vecs[i].tx     = tx;
      vecs[i].rx     = rx;
      vecs[i].chk    = chk;
      vecs[i].rd_min = rd_min;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       v;
      logic [63:0] rx;
      logic [7:0]  b;
      int          cv0;
      int          rd0;
      int          we0;
      bit          rd_ok;

      set_vec(0, "jedec",    5, 64'h9F00_0000_0000_0000, 64'h00EF_4018_0000_0000, 8'b0001_1110, 0);
      set_vec(1, "read10",   6, 64'h0300_0010_0000_0000, 64'h0000_0000_A53C_0000, 8'b0011_0000, 2);
      set_vec(2, "readwrap", 6, 64'h0300_FFFF_0000_0000, 64'h0000_0000_5AC3_0000, 8'b0011_0000, 2);
      set_vec(3, "readhi",   5, 64'h0312_0011_0000_0000, 64'h0000_0000_3C00_0000, 8'b0001_0000, 2);
      set_vec(4, "wren",     1, 64'h0600_0000_0000_0000, 64'h0,                   8'b0000_0000, 0);
      set_vec(5, "rdsr_wel", 3, 64'h0500_0000_0000_0000, 64'h0002_0200_0000_0000, 8'b0000_0110, 0);
      set_vec(6, "wrdi",     1, 64'h0400_0000_0000_0000, 64'h0,                   8'b0000_0000, 0);
      set_vec(7, "rdsr_clr", 2, 64'h0500_0000_0000_0000, 64'h0,                   8'b0000_0010, 0);
      set_vec(8, "unknown",  2, 64'hAB00_0000_0000_0000, 64'h0,                   8'b0000_0010, 0);

      rst_n   = 1'b0;
      spi_csn = 1'b1;
      spi_sck = 1'b0;
      spi_sdi = 1'b0;
      repeat (4) @(negedge clk);
      check("reset_outputs", {27'd0, spi_sdo, spi_sdo_oe, mem_rd, mem_we, mem_addr, mem_wdata,
                              cmd_code, cmd_valid}, 64'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         v   = vecs[i];
         cv0 = cv_cnt;
         rd0 = rd_cnt;
         txn(v.tx, v.nbytes, rx);
         for (int k = 0; k < v.nbytes; k++) begin
            if (v.chk[k]) check($sformatf("%s.byte%0d", v.name, k), rx[63-8*k -: 8],
                                v.rx[63-8*k -: 8]);
         end
         check({v.name, ".cmd_valid_pulses"}, cv_cnt - cv0, 1);
         check({v.name, ".cmd_code"}, cmd_code, v.tx[63:56]);
         rd_ok = (v.rd_min == 0) ? (rd_cnt == rd0) : (rd_cnt - rd0 >= v.rd_min);
         check({v.name, ".mem_rd_ok"}, rd_ok, 1);
      end

      // Unknown opcode must never enable the output driver.
      spi_csn = 1'b0;
      half();
      xfer(8'hAB, 8, b);
      xfer(8'h00, 4, b);
      check("unknown.sdo_oe", spi_sdo_oe, 1'b0);
      half();
      spi_csn = 1'b1;
      repeat (10) @(negedge clk);

      // WREN with 9 clocks leaves WEL clear.
      spi_csn = 1'b0;
      half();
      xfer(8'h06, 8, b);
      xfer(8'h00, 1, b);
      half();
      spi_csn = 1'b1;
      repeat (10) @(negedge clk);
      txn(64'h0500_0000_0000_0000, 2, rx);
      check("wren9.status", rx[55:48], 8'h00);

      // Abort READ after 13 bits: no memory access, next ID still correct.
      rd0 = rd_cnt;
      spi_csn = 1'b0;
      half();
      xfer(8'h03, 8, b);
      xfer(8'h00, 5, b);
      spi_csn = 1'b1;
      repeat (SYNC_STAGES + 1) @(posedge clk);
      #1;
      check("abort_read.sdo_oe", spi_sdo_oe, 1'b0);
      repeat (20) @(negedge clk);
      check("abort_read.no_mem_rd", rd_cnt - rd0, 0);
      txn(64'h9F00_0000_0000_0000, 2, rx);
      check("after_abort.id0", rx[55:48], 8'hEF);

      // Abort mid-response: driver released within SYNC_STAGES+1 clocks.
      spi_csn = 1'b0;
      half();
      xfer(8'h9F, 8, b);
      xfer(8'h00, 4, b);
      check("abort_id.sdo_oe_before", spi_sdo_oe, 1'b1);
      spi_csn = 1'b1;
      repeat (SYNC_STAGES + 1) @(posedge clk);
      #1;
      check("abort_id.sdo_oe_after", spi_sdo_oe, 1'b0);
      repeat (10) @(negedge clk);

      // Page program across the page boundary.
      we0 = we_cnt;
      txn(64'h0600_0000_0000_0000, 1, rx);
      txn(64'h0200_00FE_1122_3300, 7, rx);
`ifdef PAGE_PROG_EN
      check("pp.we_count", we_cnt - we0, 3);
      check("pp.mem_fe", mem[16'h00FE], 8'h11);
      check("pp.mem_ff", mem[16'h00FF], 8'h22);
      check("pp.mem_00", mem[16'h0000], 8'h33);
      txn(64'h0500_0000_0000_0000, 2, rx);
      check("pp.wel_after", rx[55:48], 8'h00);
`else
      check("pp.no_we", we_cnt - we0, 0);
      check("pp.mem_00_kept", mem[16'h0000], 8'hC3);
      txn(64'h0500_0000_0000_0000, 2, rx);
      check("pp.wel_kept", rx[55:48], 8'h02);
`endif

      // Asynchronous reset in the middle of a READ response.
      spi_csn = 1'b0;
      half();
      xfer(8'h03, 8, b);
      xfer(8'h00, 8, b);
      xfer(8'h00, 8, b);
      xfer(8'h10, 8, b);
      xfer(8'h00, 4, b);
      check("async_rst.sdo_oe_before", spi_sdo_oe, 1'b1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst.outputs", {27'd0, spi_sdo, spi_sdo_oe, mem_rd, mem_we, mem_addr,
                                  mem_wdata, cmd_code, cmd_valid}, 64'd0);
      spi_csn = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
